// File: rtl/crtc_pkg.sv
// -----------------------------------------------------------------------------
// crtc_pkg
// Shared definitions for the CRTC Wishbone register loader:
//   - crtc_state_e   : loader FSM state encoding
//   - CRTC_ADDR_PORT : adr_o value selecting the CRTC address-select port
//   - CRTC_DATA_PORT : adr_o value selecting the CRTC data port
//   - CRTC_NREGS     : default number of CRTC registers per load sequence
//   - is_bus_state() : true for states that own a Wishbone transfer
// -----------------------------------------------------------------------------
package crtc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    DAT  = 3'd2,
    GAP  = 3'd3,
    RSEL = 3'd4,
    RDAT = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } crtc_state_e;

  localparam logic        CRTC_ADDR_PORT = 1'b0;
  localparam logic        CRTC_DATA_PORT = 1'b1;
  localparam int unsigned CRTC_NREGS     = 16;

  // States in which a bus transfer is pending and the wait timer runs.
  function automatic logic is_bus_state(input crtc_state_e s);
    return (s == SEL) || (s == DAT) || (s == RSEL) || (s == RDAT);
  endfunction

endpackage

// File: rtl/crtc_wb_loader_timer.sv
// -----------------------------------------------------------------------------
// crtc_wb_loader_timer
// 8-bit wait counter guarding each Wishbone transfer of the loader.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   clr_i    in   clear the counter (entering a new state / not on the bus)
//   inc_i    in   a bus cycle passed without an accepted ack
//   expire_o out  this cycle's increment makes the counter reach TIMEOUT
// -----------------------------------------------------------------------------
module crtc_wb_loader_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  // Count value one below the limit: expiry is flagged combinationally so
  // the FSM leaves the state on the same edge the counter hits TIMEOUT.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next-count selection: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign expire_o = inc_i & (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/crtc_wb_loader.sv
// -----------------------------------------------------------------------------
// crtc_wb_loader
// Loads a 16x8 shadow register table into a 6845-style CRTC over a Wishbone
// initiator (address-select write followed by data write per register), and
// performs single register reads (address-select write, data-port read).
// Ports:
//   clk_i, rst_ni            clock / asynchronous active-low reset
//   cfg_we_i/idx_i/dat_i     shadow-table write port (ignored while busy)
//   start_i                  pulse: load registers 0..NREGS-1
//   rd_req_i, rd_idx_i       pulse: read one CRTC register
//   rd_dat_o                 last read result
//   busy_o, done_o, err_o    status: busy, completion pulse, sticky timeout
//   cyc_o, stb_o, we_o,
//   adr_o, dat_o             Wishbone initiator outputs (all registered)
//   dat_i, ack_i             Wishbone responder inputs
// -----------------------------------------------------------------------------
module crtc_wb_loader
  import crtc_pkg::*;
#(
  parameter int unsigned NREGS   = CRTC_NREGS,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cfg_we_i,
  input  logic [3:0] cfg_idx_i,
  input  logic [7:0] cfg_dat_i,
  input  logic       start_i,
  input  logic       rd_req_i,
  input  logic [4:0] rd_idx_i,
  output logic [7:0] rd_dat_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic       adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  localparam logic [4:0] NREGS_W = 5'(NREGS);

  crtc_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  shadow_q [16];
  logic [7:0]  shadow_d [16];
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic        adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  rd_dat_q, rd_dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ack_ok_s;
  logic        bus_s;
  logic        expire_s;
  logic        tmr_clr_s;
  logic        tmr_inc_s;
  logic [4:0]  idx_inc_s;

  // ack_i only counts while our strobe is actually on the bus.
  assign ack_ok_s  = stb_q & ack_i;
  assign bus_s     = is_bus_state(state_q);
  assign idx_inc_s = idx_q + 5'd1;

  // Timer restarts whenever the FSM changes state, so every transfer gets a
  // fresh budget; idle cycles of a bus state (incl. setup cycle) count.
  assign tmr_inc_s = bus_s & ~ack_ok_s;
  assign tmr_clr_s = (state_d != state_q) | ~bus_s;

  crtc_wb_loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmr_clr_s),
    .inc_i    (tmr_inc_s),
    .expire_o (expire_s)
  );

  // Next-state, bus outputs and status computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    shadow_d = shadow_q;
    cyc_d    = 1'b0;
    stb_d    = 1'b0;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rd_dat_d = rd_dat_q;
    err_d    = err_q;

    // The table is only writable while idle so a load never sees torn data.
    if (cfg_we_i && (state_q == IDLE)) begin
      shadow_d[cfg_idx_i] = cfg_dat_i;
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SEL;
          idx_d   = 5'd0;
          err_d   = 1'b0;
        end else if (rd_req_i) begin
          state_d  = RSEL;
          rd_idx_d = rd_idx_i;
          err_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      SEL, DAT, RSEL, RDAT: begin
        // Address/data are set from the first cycle of the state and stay
        // constant, so they are stable for the whole strobe.
        case (state_q)
          SEL: begin
            adr_d = CRTC_ADDR_PORT;
            dat_d = {3'b000, idx_q};
            we_d  = 1'b1;
          end
          DAT: begin
            adr_d = CRTC_DATA_PORT;
            dat_d = shadow_q[idx_q[3:0]];
            we_d  = 1'b1;
          end
          RSEL: begin
            adr_d = CRTC_ADDR_PORT;
            dat_d = {3'b000, rd_idx_q};
            we_d  = 1'b1;
          end
          default: begin
            adr_d = CRTC_DATA_PORT;
            we_d  = 1'b0;
          end
        endcase

        if (expire_s) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (ack_ok_s) begin
          case (state_q)
            SEL:     state_d = DAT;
            DAT:     state_d = GAP;
            RSEL:    state_d = RDAT;
            default: begin
              state_d  = DONE;
              rd_dat_d = dat_i;
            end
          endcase
        end else begin
          // First cycle raises the strobe; it then holds until ack/timeout.
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end
      end

      GAP: begin
        idx_d = idx_inc_s;
        if (idx_inc_s < NREGS_W) begin
          state_d = SEL;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      rd_idx_q <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 8'd0;
      end
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 1'b0;
      dat_q    <= 8'd0;
      rd_dat_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      shadow_q <= shadow_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rd_dat_q <= rd_dat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cyc_o    = cyc_q;
  assign stb_o    = stb_q;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign rd_dat_o = rd_dat_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_crtc_wb_loader.sv
// -----------------------------------------------------------------------------
// tb_crtc_wb_loader
// Directed bench for crtc_wb_loader with a behavioural CRTC responder
// (mode 0: zero-wait ack, 1: three wait states, 2: never acks) and a
// transfer log recorded on every accepted ack.
// -----------------------------------------------------------------------------
module tb_crtc_wb_loader;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cfg_we_i;
  logic [3:0] cfg_idx_i;
  logic [7:0] cfg_dat_i;
  logic       start_i;
  logic       rd_req_i;
  logic [4:0] rd_idx_i;
  logic [7:0] rd_dat_o;
  logic       busy_o, done_o, err_o;
  logic       cyc_o, stb_o, we_o, adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;

  crtc_wb_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_dat_i(cfg_dat_i),
    .start_i(start_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_dat_o(rd_dat_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Responder model
  int         mode  = 0;
  int         rwait = 0;
  int         slen  = 0;
  logic [7:0] crtc_regs [32];
  logic [4:0] crtc_sel = 5'd0;

  logic       log_we  [512];
  logic       log_adr [512];
  logic [7:0] log_dat [512];
  int         log_len [512];
  int         log_n    = 0;
  int         done_cnt = 0;

  assign ack_i = (mode == 0) ? (cyc_o & stb_o) :
                 (mode == 1) ? (cyc_o & stb_o & (rwait == 3)) : 1'b0;
  assign dat_i = crtc_regs[crtc_sel];

  always @(posedge clk_i) begin
    if (cyc_o && stb_o && !ack_i) rwait <= rwait + 1;
    else rwait <= 0;
    if (stb_o && !ack_i) slen <= slen + 1;
    else slen <= 0;
    if (done_o) done_cnt <= done_cnt + 1;
    if (cyc_o && stb_o && ack_i) begin
      log_we[log_n[8:0]]  <= we_o;
      log_adr[log_n[8:0]] <= adr_o;
      log_dat[log_n[8:0]] <= dat_o;
      log_len[log_n[8:0]] <= slen + 1;
      log_n <= log_n + 1;
      if (we_o) begin
        if (adr_o) crtc_regs[crtc_sel] <= dat_o;
        else crtc_sel <= dat_o[4:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic r, input logic [4:0] ri);
    @(negedge clk_i);
    start_i  = s;
    rd_req_i = r;
    rd_idx_i = ri;
    @(negedge clk_i);
    start_i  = 1'b0;
    rd_req_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] i, input logic [7:0] d);
    @(negedge clk_i);
    cfg_we_i  = 1'b1;
    cfg_idx_i = i;
    cfg_dat_i = d;
    @(negedge clk_i);
    cfg_we_i  = 1'b0;
  endtask

  // which: 0 = done_o, 1 = err_o; k = cycles waited, -1 if the bound expired
  task automatic wait_sig(input int which, input int limit, output int k);
    k = -1;
    for (int c = 0; c < limit && k < 0; c++) begin
      if ((which == 0 && done_o === 1'b1) || (which == 1 && err_o === 1'b1)) k = c;
      else @(negedge clk_i);
    end
  endtask

  task automatic chk_load(input string tag, input int base);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_sel_adr"}, 32'(log_adr[base + 2*i]), 32'd0);
      chk({tag, "_sel_dat"}, 32'(log_dat[base + 2*i]), 32'(i));
      chk({tag, "_sel_we"},  32'(log_we[base + 2*i]),  32'd1);
      chk({tag, "_dat_adr"}, 32'(log_adr[base + 2*i + 1]), 32'd1);
      chk({tag, "_dat_dat"}, 32'(log_dat[base + 2*i + 1]), 32'(8'h10 + 8'(i)));
      chk({tag, "_dat_we"},  32'(log_we[base + 2*i + 1]),  32'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base;
    int d0;
    int nrd;
    int found;

    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = 4'd0; cfg_dat_i = 8'd0;
    start_i = 1'b0; rd_req_i = 1'b0; rd_idx_i = 5'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_rd_dat", 32'(rd_dat_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) cfg_write(4'(i), 8'h10 + 8'(i));

    // Full load, zero-wait responder
    base = log_n; d0 = done_cnt;
    pulse(1'b1, 1'b0, 5'd0);
    chk("t1_busy", 32'(busy_o), 32'd1);
    wait_sig(0, 2000, k);
    chk("t1_done_cycle", 32'(k), 32'd80);
    @(negedge clk_i);
    chk("t1_done_pulse", 32'(done_o), 32'd0);
    chk("t1_idle", 32'(busy_o), 32'd0);
    chk("t1_xfers", 32'(log_n - base), 32'd32);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk_load("t1", base);

    // Full load, three wait states per ack
    mode = 1; base = log_n; d0 = done_cnt;
    pulse(1'b1, 1'b0, 5'd0);
    wait_sig(0, 2000, k);
    chk("t2_done_cycle", 32'(k), 32'd176);
    repeat (5) @(negedge clk_i);
    chk("t2_xfers", 32'(log_n - base), 32'd32);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 32; i++) chk("t2_stb_len", 32'(log_len[base + i]), 32'd4);
    chk_load("t2", base);

    // Responder never acks
    mode = 2; base = log_n; d0 = done_cnt;
    pulse(1'b1, 1'b0, 5'd0);
    wait_sig(1, 1000, k);
    chk("t3_err_cycle", 32'(k), 32'd255);
    chk("t3_cyc", 32'(cyc_o), 32'd0);
    chk("t3_stb", 32'(stb_o), 32'd0);
    chk("t3_busy_err", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk("t3_idle", 32'(busy_o), 32'd0);
    chk("t3_err_sticky", 32'(err_o), 32'd1);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t3_no_xfer", 32'(log_n - base), 32'd0);
    mode = 0;
    pulse(1'b1, 1'b0, 5'd0);
    chk("t3_err_cleared", 32'(err_o), 32'd0);
    wait_sig(0, 2000, k);
    chk("t3_reload_done", 32'(k), 32'd80);

    // Register read: R12 = 0x2A loaded into the CRTC, then read back
    cfg_write(4'd12, 8'h2A);
    pulse(1'b1, 1'b0, 5'd0);
    wait_sig(0, 2000, k);
    chk("t4_load_done", 32'(k), 32'd80);
    @(negedge clk_i);
    base = log_n; d0 = done_cnt;
    pulse(1'b0, 1'b1, 5'd12);
    wait_sig(0, 200, k);
    chk("t4_rd_cycle", 32'(k), 32'd4);
    chk("t4_rd_dat", 32'(rd_dat_o), 32'h2A);
    @(negedge clk_i);
    chk("t4_xfers", 32'(log_n - base), 32'd2);
    chk("t4_sel_we", 32'(log_we[base]), 32'd1);
    chk("t4_sel_adr", 32'(log_adr[base]), 32'd0);
    chk("t4_sel_dat", 32'(log_dat[base]), 32'h0C);
    chk("t4_rd_we", 32'(log_we[base + 1]), 32'd0);
    chk("t4_rd_adr", 32'(log_adr[base + 1]), 32'd1);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t4_rd_hold", 32'(rd_dat_o), 32'h2A);

    // start_i + rd_req_i together; cfg write and new requests while busy
    base = log_n; d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 5'd3;
    @(negedge clk_i);
    start_i = 1'b0; rd_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_idx_i = 4'd5; cfg_dat_i = 8'hEE;
    start_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 5'd9;
    @(negedge clk_i);
    cfg_we_i = 1'b0; start_i = 1'b0; rd_req_i = 1'b0;
    wait_sig(0, 2000, k);
    chk("t5_done_cycle", 32'(k), 32'd76);
    repeat (10) @(negedge clk_i);
    chk("t5_xfers", 32'(log_n - base), 32'd32);
    nrd = 0;
    for (int i = 0; i < 32; i++) if (log_we[base + i] == 1'b0) nrd++;
    chk("t5_no_read", 32'(nrd), 32'd0);
    chk("t5_shadow5", 32'(log_dat[base + 11]), 32'h15);
    chk("t5_shadow12", 32'(log_dat[base + 25]), 32'h2A);
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t5_idle", 32'(busy_o), 32'd0);

    // Reset during the data transfer of register 7
    base = log_n;
    pulse(1'b1, 1'b0, 5'd0);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (stb_o === 1'b1 && adr_o === 1'b1 && dat_o === 8'h17) found = 1;
      else @(negedge clk_i);
    end
    chk("t6_found_r7", 32'(found), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_cyc", 32'(cyc_o), 32'd0);
    chk("t6_stb", 32'(stb_o), 32'd0);
    chk("t6_we", 32'(we_o), 32'd0);
    chk("t6_adr", 32'(adr_o), 32'd0);
    chk("t6_dat", 32'(dat_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_rd_dat", 32'(rd_dat_o), 32'd0);
    chk("t6_xfers_before", 32'(log_n - base), 32'd15);
    @(negedge clk_i);
    rst_ni = 1'b1;
    base = log_n;
    pulse(1'b1, 1'b0, 5'd0);
    wait_sig(0, 2000, k);
    chk("t6_reload_done", 32'(k), 32'd80);
    @(negedge clk_i);
    chk("t6_reload_xfers", 32'(log_n - base), 32'd32);
    chk("t6_first_adr", 32'(log_adr[base]), 32'd0);
    chk("t6_first_idx", 32'(log_dat[base]), 32'd0);
    chk("t6_first_data", 32'(log_dat[base + 1]), 32'd0);
    chk("t6_r7_idx", 32'(log_dat[base + 14]), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
